ibus_line_buffer: RTL
=====================

# ibus_line_buffer

Instruction-side bus responder that sits between the fetch-stage PC/fetch block and the cache bus (cbus). It answers `ireq` lookups from a single buffered instruction line. On a miss it performs one aligned cbus INCR burst read to refill the line, then answers the original request. Hits are answered combinationally in the request cycle, so straight-line fetch inside a line needs no stall.

## Interface
Parameters:
- `LINE_WORDS`, default 8: 64-bit beats per line. Power of two, 2..16. Line size = `LINE_WORDS`*8 bytes.
- `OFS`, derived, = log2(`LINE_WORDS`)+3: byte-offset width within the line.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `ireq`  in  `ibus_req_t`  fetch request:
  - `valid`: 1 bit.
  - `addr`: 64 bits.
- `iresp`  out  `ibus_resp_t`  fetch response:
  - `addr_ok`: 1 bit.
  - `data_ok`: 1 bit.
  - `data`: 32 bits.
- `inv`  in  1  invalidate the buffered line (fence/self-modifying code).
- `creq`  out  `cbus_req_t`  cbus request:
  - `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`, `burst`.
- `cresp`  in  `cbus_resp_t`  cbus response:
  - `ready`: 1 bit.
  - `last`: 1 bit.
  - `data`: 64 bits.

## Operation
Storage:
- `line[LINE_WORDS]` of 64 bits.
- `tag` = `addr[63:OFS]`.
- `line_valid`, 1 bit.
- beat counter `cnt`, log2(`LINE_WORDS`) bits.
- `fill_tag` latch.
- `inv_pend`, 1 bit.

State machine:
- IDLE:
  - hit = `ireq.valid & line_valid & (ireq.addr[63:OFS]==tag)`.
  - On hit: `addr_ok`=`data_ok`=1. Select beat `line[ireq.addr[OFS-1:3]]`; `data` = `addr[2]` ? beat[63:32] : beat[31:0].
  - On miss with `ireq.valid`=1: latch `fill_tag`, clear `cnt` and `inv_pend`, go to FILL. `iresp` stays 0.
  - `ireq.valid`=0: `iresp` = 0, no state change.
- FILL:
  - Drive `creq.valid`=1, `is_write`=0, `size`=MSIZE8 (3), `burst`=INCR, `len`=`LINE_WORDS`-1, `strobe`=0, `data`=0.
  - `creq.addr` = {`fill_tag`, OFS'b0}.
  - All `creq` fields are held constant for the whole burst.
  - Each cycle with `cresp.ready`=1: `line[cnt]`<=`cresp.data`, then `cnt`++.
  - When `cresp.ready & cresp.last`: `tag`<=`fill_tag`, `line_valid`<=`~inv_pend & ~inv`, go to IDLE. `creq.valid` drops the next cycle.
  - `iresp` is 0 for the whole of FILL.

Boundary rules:
- **Address bits:** `addr[1:0]` is ignored (fetch never issues a misaligned valid request).
- **Request change during FILL:** e.g. a flush redirects the PC. The burst is never aborted. The fill completes, then IDLE re-evaluates the current `ireq` (a hit, or a new miss).
- **`inv` in IDLE:** `line_valid`<=0 next cycle. `inv` does not mask a same-cycle hit.
- **`inv` during FILL:** sets `inv_pend`. The completed line is written but left invalid, so the next request misses and refills.
- **Early `last`:** `cresp.last` before `LINE_WORDS` beats ends the fill anyway; unwritten words keep stale data.
- **Counter wrap:** `cnt` wraps naturally. No more than `LINE_WORDS` beats are expected.
- **Reset mid-FILL:** return to IDLE, clear `line_valid`, drop `creq.valid` in the same edge. No wait for `last`.

## Timing
- Reset values:
  - state IDLE; `line_valid`=0, `inv_pend`=0, `cnt`=0.
  - `creq` all zero; `iresp` all zero. `line` contents are don't-care.
- Hit latency: 0 cycles. `iresp` is combinational from `ireq` and registered state.
- Miss, with cycle 0 = request cycle:
  - cycle 1: `creq.valid`=1.
  - cycles 1..N: beats arrive, last beat in cycle N.
  - cycle N+1: IDLE with the line valid; the same request hits.
  - Minimum miss penalty with `ready` every cycle: `LINE_WORDS`+1 stall cycles.
- `creq.valid` never falls before the `ready & last` beat.
- `addr_ok` and `data_ok` are always equal.

## Test plan
- **Reset then miss:** reset; `ireq` valid, addr 0x8000_0000. Expect cycle 1 `creq.valid`=1, addr 0x8000_0000, len 7, size 3. Feed 8 beats, beat i = 0x1111_0000_0000_0000+i, ready every cycle. One cycle after last, expect `data_ok`=1 and `data`=0x0000_0000.
- **Sequential hits:** after that fill, addr 0x8000_0004 returns data 0x1111_0000; addr 0x8000_0038 returns 0x0000_0007. All same cycle, no `creq`.
- **Next-line miss:** addr 0x8000_0040 gives `iresp`=0 and `creq.addr` 0x8000_0040. Insert ready gaps (ready=0 on alternate cycles). Expect `creq` stable and all 8 beats captured.
- **Redirect mid-fill:** `ireq.addr` changes to 0x8000_1000 at beat 3. Expect the burst for 0x8000_0040 to finish, then a new miss burst at 0x8000_1000.
- **`inv` during fill:** pulse `inv` at beat 5. After last, the same address misses again and a second burst is issued.
- **Reset mid-fill:** assert `reset` at beat 4. Next cycle `creq.valid`=0, `iresp`=0, and the prior address misses.

Source files
------------

// File: rtl/ibus_line_buffer.sv
// ibus_line_buffer: single-line instruction buffer answering ibus hits combinationally and refilling by cbus burst
package ibus_line_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} axi_burst_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    axi_burst_t  burst;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
  localparam logic [2:0] MSIZE8 = 3'd3;
endpackage

module ibus_line_buffer
  import ibus_line_buffer_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  localparam int CW = $clog2(LINE_WORDS),
  localparam int OFS = CW + 3
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  logic       inv,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic [63:0] line [LINE_WORDS];
  logic [63:OFS] tag, fill_tag;
  logic line_valid, inv_pend, hit;
  logic [CW-1:0] cnt;
  logic [63:0] beat;
  logic unused_addr;
  assign unused_addr = ^ireq.addr[1:0];
  assign hit = state == IDLE && ireq.valid && line_valid && ireq.addr[63:OFS] == tag;
  assign beat = line[ireq.addr[OFS-1:3]];
  // hit response is purely combinational so in-line fetch never stalls
  always_comb begin
    iresp.addr_ok = hit;
    iresp.data_ok = hit;
    iresp.data = hit ? (ireq.addr[2] ? beat[63:32] : beat[31:0]) : '0;
  end
  // burst request depends only on registered state, so it stays constant for the whole fill
  always_comb begin
    creq = '0;
    if (state == FILL) begin
      creq.valid = 1'b1;
      creq.size = MSIZE8;
      creq.addr = {fill_tag, {OFS{1'b0}}};
      creq.len = 4'(LINE_WORDS - 1);
      creq.burst = INCR;
    end
  end
  // lookup/refill sequencing; a fill always runs to its last beat unless reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      line_valid <= 1'b0;
      inv_pend <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (inv) line_valid <= 1'b0;
      if (ireq.valid && !hit) begin
        fill_tag <= ireq.addr[63:OFS];
        cnt <= '0;
        inv_pend <= 1'b0;
        state <= FILL;
      end
    end else begin
      if (inv) inv_pend <= 1'b1;
      if (cresp.ready) begin
        line[cnt] <= cresp.data;
        cnt <= cnt + 1'b1;
      end
      if (cresp.ready && cresp.last) begin
        tag <= fill_tag;
        line_valid <= ~inv_pend & ~inv;
        state <= IDLE;
      end
    end
  end
endmodule
